cosim_rr_sched: RTL

Shares one WIDTH-bit output datapath among NREQ requesters. Each cycle it picks at most one valid requester and registers that requester's data into a single-entry output stage with a valid/ready handshake. Arbitration is round-robin or fixed-priority, chosen at elaboration by a conditional generate on MODE. A grant stays locked to one source until that source's last beat is accepted, so multi-beat packets are never interleaved.

---
 rtl/cosim_rr_sched.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cosim_rr_sched.sv
// ---------------------------------------------------------------------------
// cosim_rr_sched
//   Shares one WIDTH-bit output datapath among NREQ requesters. At most one
//   requester is granted per cycle and its beat is captured into a single-entry
//   output register with a valid/ready handshake. Arbitration is round-robin
//   (MODE=1) or fixed lowest-index priority (MODE=0). Once a source has a beat
//   accepted without req_last, the grant stays locked to that source until its
//   last beat is accepted, so packets are never interleaved.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester beat valid
//   req_last   per-requester last-beat flag (qualified by req_valid)
//   req_data   requester i's beat in bits [i*WIDTH +: WIDTH]
//   req_ready  one-hot (or zero) grant; combinational from req_valid, state
//              and out_ready
//   out_valid  output register holds a beat
//   out_data   registered beat
//   out_src    index of the requester that supplied out_data
//   out_last   registered req_last of the accepted beat
//   out_ready  downstream accepts the held beat
//   locked     grant is held mid-packet
// ---------------------------------------------------------------------------
module cosim_rr_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 128,
    parameter int MODE  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(NREQ)-1:0]  out_src,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     locked
);

    localparam int SW = $clog2(NREQ);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Registered state
    lock_state_t       r_lock_state;
    logic [SW-1:0]     r_lock_src;
    logic [SW-1:0]     r_rr_ptr;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SW-1:0]     r_out_src;
    logic              r_out_last;

    // Next-state values
    lock_state_t       w_lock_state_next;
    logic [SW-1:0]     w_lock_src_next;
    logic [SW-1:0]     w_rr_ptr_next;
    logic              w_out_valid_next;
    logic [WIDTH-1:0]  w_out_data_next;
    logic [SW-1:0]     w_out_src_next;
    logic              w_out_last_next;

    // Arbitration
    logic              w_sel_found;   // arbiter result ignoring the lock
    logic [SW-1:0]     w_sel_idx;
    logic              w_found;       // final candidate after the lock
    logic [SW-1:0]     w_cand;
    logic              w_can_load;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_data_arr [NREQ];

    // -----------------------------------------------------------------------
    // Arbiter selected at elaboration time
    // -----------------------------------------------------------------------
    generate
        if (MODE == 1) begin : g_rr
            // Scan starts one past the last granted source and wraps, so the
            // most recently served requester has the lowest priority.
            logic [SW-1:0] w_idx;
            always_comb begin
                w_sel_found = 1'b0;
                w_sel_idx   = '0;
                w_idx       = '0;
                for (int k = 1; k <= NREQ; k++) begin
                    w_idx = SW'((int'(r_rr_ptr) + k) % NREQ);
                    if (!w_sel_found && req_valid[w_idx]) begin
                        w_sel_found = 1'b1;
                        w_sel_idx   = w_idx;
                    end
                end
            end
        end else begin : g_fp
            always_comb begin
                w_sel_found = 1'b0;
                w_sel_idx   = '0;
                for (int i = 0; i < NREQ; i++) begin
                    if (!w_sel_found && req_valid[i]) begin
                        w_sel_found = 1'b1;
                        w_sel_idx   = SW'(i);
                    end
                end
            end
        end
    endgenerate

    // While locked only the owning source may transfer; if it has dropped
    // req_valid nobody is granted.
    always_comb begin
        w_found = w_sel_found;
        w_cand  = w_sel_idx;
        if (r_lock_state == LOCKED) begin
            w_found = req_valid[r_lock_src];
            w_cand  = r_lock_src;
        end
    end

    assign w_can_load = !r_out_valid || out_ready;
    assign w_xfer     = w_can_load && w_found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
            assign req_ready[gi]  = w_xfer && (w_cand == SW'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_lock_state_next = r_lock_state;
        w_lock_src_next   = r_lock_src;
        w_rr_ptr_next     = r_rr_ptr;
        w_out_valid_next  = r_out_valid;
        w_out_data_next   = r_out_data;
        w_out_src_next    = r_out_src;
        w_out_last_next   = r_out_last;

        if (w_xfer) begin
            // A load may coincide with a drain: back-to-back with no bubble.
            w_out_valid_next = 1'b1;
            w_out_data_next  = w_data_arr[w_cand];
            w_out_src_next   = w_cand;
            w_out_last_next  = req_last[w_cand];
            w_rr_ptr_next    = w_cand;
            if (req_last[w_cand]) begin
                w_lock_state_next = UNLOCKED;
            end else begin
                w_lock_state_next = LOCKED;
                w_lock_src_next   = w_cand;
            end
        end else if (r_out_valid && out_ready) begin
            w_out_valid_next = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_state <= UNLOCKED;
            r_lock_src   <= '0;
            r_rr_ptr     <= SW'(NREQ - 1);
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_lock_state <= w_lock_state_next;
            r_lock_src   <= w_lock_src_next;
            r_rr_ptr     <= w_rr_ptr_next;
            r_out_valid  <= w_out_valid_next;
            r_out_data   <= w_out_data_next;
            r_out_src    <= w_out_src_next;
            r_out_last   <= w_out_last_next;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_last  = r_out_last;
    assign locked    = (r_lock_state == LOCKED);

endmodule
